ddr_arbiter: RTL and testbench

// Shares the single DDRAM burst port between N_PORTS requesters (port 0 = ROM

---
 rtl/ddr_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/ddr_arbiter.sv | 143 ++++++++++++++
 tb/tb_ddr_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types and widths for the DDRAM burst-port arbiter.
package ddr_pkg;

  localparam int DDR_ADDR_W  = 32;
  localparam int DDR_DATA_W  = 64;
  localparam int DDR_BURST_W = 8;
  localparam int DDR_MASK_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ_CMD,
    READ_DATA,
    WRITE
  } ddr_arb_state_t;

endpackage : ddr_pkg

// File: rtl/rr_arbiter.sv
// N-way rotate-priority encoder: the search starts just after the last winner,
// or at index 0 when fixed priority is selected.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  input  logic             fixed_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_o
);

  logic [IDX_W-1:0] idx;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a value held and infer a latch.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = fixed_i ? IDX_W'(k) : IDX_W'((int'(last_i) + 1 + k) % N);
      if (!any_o && req_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/ddr_arbiter.sv
// Shares the DDRAM burst port between N_PORTS requesters, granting whole bursts.
// A grant is made only from IDLE, so a burst in flight is never pre-empted.
module ddr_arbiter
  import ddr_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                          clk_sys,
  input  logic                          rst_n,
  input  logic [N_PORTS-1:0]            in_rd,
  input  logic [N_PORTS-1:0]            in_wr,
  input  logic [N_PORTS*DDR_ADDR_W-1:0]  in_addr,
  input  logic [N_PORTS*DDR_BURST_W-1:0] in_burst_len,
  input  logic [N_PORTS*DDR_MASK_W-1:0]  in_mask,
  input  logic [N_PORTS*DDR_DATA_W-1:0]  in_din,
  output logic [N_PORTS-1:0]            in_wait_req,
  output logic [N_PORTS-1:0]            in_valid,
  output logic [N_PORTS-1:0]            in_burst_done,
  output logic [DDR_DATA_W-1:0]         in_dout,
  output logic                          ddr_rd,
  output logic                          ddr_wr,
  output logic [DDR_ADDR_W-1:0]         ddr_addr,
  output logic [DDR_BURST_W-1:0]        ddr_burst_len,
  output logic [DDR_MASK_W-1:0]         ddr_mask,
  output logic [DDR_DATA_W-1:0]         ddr_din,
  input  logic                          ddr_wait_req,
  input  logic                          ddr_valid,
  input  logic [DDR_DATA_W-1:0]         ddr_dout
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  ddr_arb_state_t       state_q, state_d;
  logic [IDX_W-1:0]     g_q, g_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [DDR_BURST_W-1:0] cnt_q, cnt_d;
  logic [N_PORTS-1:0]   done_q, done_d;

  logic [IDX_W-1:0]       arb_grant;
  logic                   arb_any;
  logic [DDR_BURST_W-1:0] new_len;
  logic                   in_burst;

  rr_arbiter #(
    .N     (N_PORTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (in_rd | in_wr),
    .last_i  (last_q),
    .fixed_i (FIXED_PRIO != 0),
    .grant_o (arb_grant),
    .any_o   (arb_any)
  );

  assign new_len  = in_burst_len[arb_grant*DDR_BURST_W +: DDR_BURST_W];
  assign in_burst = (state_q == READ_CMD) || (state_q == WRITE);

  // Command and data paths follow the granted port; only rd/wr are gated by state.
  always_comb begin
    ddr_addr      = in_addr[g_q*DDR_ADDR_W +: DDR_ADDR_W];
    ddr_burst_len = in_burst_len[g_q*DDR_BURST_W +: DDR_BURST_W];
    ddr_mask      = in_mask[g_q*DDR_MASK_W +: DDR_MASK_W];
    ddr_din       = in_din[g_q*DDR_DATA_W +: DDR_DATA_W];
    ddr_rd        = (state_q == READ_CMD) && in_rd[g_q];
    ddr_wr        = (state_q == WRITE) && in_wr[g_q];
    in_dout       = ddr_dout;
    in_burst_done = done_q;
    in_wait_req   = '1;
    in_valid      = '0;
    if (in_burst) begin
      in_wait_req[g_q] = ddr_wait_req;
    end
    if (state_q == READ_DATA) begin
      in_valid[g_q] = ddr_valid;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          g_d     = arb_grant;
          last_d  = arb_grant;
          cnt_d   = (new_len == '0) ? DDR_BURST_W'(1) : new_len;
          // A port raising both rd and wr is served as a read.
          state_d = in_rd[arb_grant] ? READ_CMD : WRITE;
        end
      end
      READ_CMD: begin
        if (!in_rd[g_q]) begin
          state_d = IDLE;
        end else if (!ddr_wait_req) begin
          state_d = READ_DATA;
        end
      end
      READ_DATA: begin
        if (ddr_valid) begin
          cnt_d = cnt_q - DDR_BURST_W'(1);
          if (cnt_q == DDR_BURST_W'(1)) begin
            state_d     = IDLE;
            done_d[g_q] = 1'b1;
          end
        end
      end
      WRITE: begin
        // A low in_wr is a gap in the burst, not its end.
        if (in_wr[g_q] && !ddr_wait_req) begin
          cnt_d = cnt_q - DDR_BURST_W'(1);
          if (cnt_q == DDR_BURST_W'(1)) begin
            state_d     = IDLE;
            done_d[g_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value, independent of statement order.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= IDX_W'(N_PORTS - 1);
      cnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule : ddr_arbiter

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter: a cycle table for single-port reads plus
// hand sequences for contention, stalled writes, mid-burst requests and reset.
module tb_ddr_arbiter;

  logic         clk_sys = 1'b0;
  logic         rst_n;
  logic [1:0]   in_rd, in_wr;
  logic [63:0]  in_addr;
  logic [15:0]  in_burst_len, in_mask;
  logic [127:0] in_din;
  logic         ddr_wait_req, ddr_valid;
  logic [63:0]  ddr_dout;

  logic [1:0]  wait_req, valid, done;
  logic [63:0] dout, ddr_din;
  logic        ddr_rd, ddr_wr;
  logic [31:0] ddr_addr;
  logic [7:0]  ddr_burst_len, ddr_mask;

  logic [1:0]  fp_wait_req, fp_valid, fp_done;
  logic [63:0] fp_dout, fp_ddr_din;
  logic        fp_ddr_rd, fp_ddr_wr;
  logic [31:0] fp_ddr_addr;
  logic [7:0]  fp_ddr_burst_len, fp_ddr_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  ddr_arbiter #(.N_PORTS(2), .FIXED_PRIO(0)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .in_rd(in_rd), .in_wr(in_wr),
    .in_addr(in_addr), .in_burst_len(in_burst_len), .in_mask(in_mask), .in_din(in_din),
    .in_wait_req(wait_req), .in_valid(valid), .in_burst_done(done), .in_dout(dout),
    .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr), .ddr_burst_len(ddr_burst_len),
    .ddr_mask(ddr_mask), .ddr_din(ddr_din), .ddr_wait_req(ddr_wait_req),
    .ddr_valid(ddr_valid), .ddr_dout(ddr_dout)
  );

  ddr_arbiter #(.N_PORTS(2), .FIXED_PRIO(1)) dut_fp (
    .clk_sys(clk_sys), .rst_n(rst_n), .in_rd(in_rd), .in_wr(in_wr),
    .in_addr(in_addr), .in_burst_len(in_burst_len), .in_mask(in_mask), .in_din(in_din),
    .in_wait_req(fp_wait_req), .in_valid(fp_valid), .in_burst_done(fp_done), .in_dout(fp_dout),
    .ddr_rd(fp_ddr_rd), .ddr_wr(fp_ddr_wr), .ddr_addr(fp_ddr_addr),
    .ddr_burst_len(fp_ddr_burst_len), .ddr_mask(fp_ddr_mask), .ddr_din(fp_ddr_din),
    .ddr_wait_req(ddr_wait_req), .ddr_valid(ddr_valid), .ddr_dout(ddr_dout)
  );

  typedef struct {
    logic [1:0] rd;
    logic [7:0] len;
    logic       dwait;
    logic       dvalid;
    logic       exp_rd;
    logic [1:0] exp_wait;
    logic [1:0] exp_valid;
    logic [1:0] exp_done;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic [1:0] rd, logic [7:0] len, logic dw, logic dv,
                              logic er, logic [1:0] ew, logic [1:0] ev, logic [1:0] ed);
    vec_t v;
    v.rd = rd; v.len = len; v.dwait = dw; v.dvalid = dv;
    v.exp_rd = er; v.exp_wait = ew; v.exp_valid = ev; v.exp_done = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    in_rd = '0; in_wr = '0; ddr_wait_req = 1'b0; ddr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    tick();
  endtask

  logic [63:0] words[3];
  logic [63:0] got[$];
  int rr_seq[$];
  int fp_seq[$];
  int widx;
  logic [5:0] wr_pat, wait_pat;

  initial begin
    rst_n = 1'b0;
    in_rd = '0; in_wr = '0; in_din = '0; in_mask = '0;
    in_addr = {32'h0000_0200, 32'h0000_0100};
    in_burst_len = '0;
    ddr_wait_req = 1'b0; ddr_valid = 1'b0; ddr_dout = 64'hDEAD_BEEF_0123_4567;
    #12;
    check("reset ddr_rd", ddr_rd, 1'b0);
    check("reset ddr_wr", ddr_wr, 1'b0);
    check("reset wait_req", wait_req, 2'b11);
    check("reset valid", valid, 2'b00);
    check("reset done", done, 2'b00);
    @(negedge clk_sys);
    rst_n = 1'b1;
    tick();

    // Single read len 4, stray valid in IDLE, len 0 as 1, rd dropped in READ_CMD.
    vecs[0]  = mk(2'b01, 8'd4, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    vecs[1]  = mk(2'b01, 8'd4, 0, 0, 1, 2'b10, 2'b00, 2'b00);
    vecs[2]  = mk(2'b00, 8'd4, 0, 1, 0, 2'b11, 2'b01, 2'b00);
    vecs[3]  = mk(2'b00, 8'd4, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    vecs[4]  = mk(2'b00, 8'd4, 0, 1, 0, 2'b11, 2'b01, 2'b00);
    vecs[5]  = mk(2'b00, 8'd4, 0, 1, 0, 2'b11, 2'b01, 2'b00);
    vecs[6]  = mk(2'b00, 8'd4, 0, 1, 0, 2'b11, 2'b01, 2'b00);
    vecs[7]  = mk(2'b00, 8'd4, 0, 1, 0, 2'b11, 2'b00, 2'b01);
    vecs[8]  = mk(2'b00, 8'd4, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    vecs[9]  = mk(2'b01, 8'd0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    vecs[10] = mk(2'b01, 8'd0, 1, 0, 1, 2'b11, 2'b00, 2'b00);
    vecs[11] = mk(2'b01, 8'd0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
    vecs[12] = mk(2'b00, 8'd0, 0, 1, 0, 2'b11, 2'b01, 2'b00);
    vecs[13] = mk(2'b00, 8'd0, 0, 0, 0, 2'b11, 2'b00, 2'b01);
    vecs[14] = mk(2'b01, 8'd2, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    vecs[15] = mk(2'b00, 8'd2, 1, 0, 0, 2'b11, 2'b00, 2'b00);
    vecs[16] = mk(2'b00, 8'd2, 0, 1, 0, 2'b11, 2'b00, 2'b00);
    vecs[17] = mk(2'b00, 8'd2, 0, 0, 0, 2'b11, 2'b00, 2'b00);

    for (int i = 0; i < 18; i++) begin
      in_rd = vecs[i].rd;
      in_burst_len = {8'd0, vecs[i].len};
      ddr_wait_req = vecs[i].dwait;
      ddr_valid = vecs[i].dvalid;
      @(negedge clk_sys);
      check($sformatf("v%0d ddr_rd", i), ddr_rd, vecs[i].exp_rd);
      check($sformatf("v%0d wait_req", i), wait_req, vecs[i].exp_wait);
      check($sformatf("v%0d valid", i), valid, vecs[i].exp_valid);
      check($sformatf("v%0d done", i), done, vecs[i].exp_done);
      if (vecs[i].exp_rd) begin
        check($sformatf("v%0d ddr_addr", i), ddr_addr, 32'h0000_0100);
        check($sformatf("v%0d ddr_burst_len", i), ddr_burst_len, vecs[i].len);
      end
      tick();
    end
    check("dout broadcast", dout, 64'hDEAD_BEEF_0123_4567);

    // Contention: both ports read continuously, len 2.
    do_reset();
    in_burst_len = {8'd2, 8'd2};
    in_rd = 2'b11; ddr_valid = 1'b1; ddr_wait_req = 1'b0;
    for (int c = 0; c < 24 && (rr_seq.size() < 4 || fp_seq.size() < 4); c++) begin
      @(negedge clk_sys);
      if (ddr_rd) begin
        rr_seq.push_back(wait_req[0] ? 1 : 0);
        check("rr addr follows grant", ddr_addr, wait_req[0] ? 32'h200 : 32'h100);
      end
      if (fp_ddr_rd) fp_seq.push_back(fp_wait_req[0] ? 1 : 0);
      tick();
    end
    check("rr grant count", rr_seq.size(), 4);
    check("fp grant count", fp_seq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr grant %0d", k), (k < rr_seq.size()) ? rr_seq[k] : 99, k % 2);
      check($sformatf("fp grant %0d", k), (k < fp_seq.size()) ? fp_seq[k] : 99, 0);
    end

    // Write on port 1 with a stall on the 2nd attempt and a gap.
    do_reset();
    words[0] = 64'hAAAA_0000_0000_000A;
    words[1] = 64'hBBBB_0000_0000_000B;
    words[2] = 64'hCCCC_0000_0000_000C;
    in_mask = {8'h5A, 8'h00};
    in_burst_len = {8'd3, 8'd0};
    wr_pat   = 6'b110111;
    wait_pat = 6'b000100;
    widx = 0;
    for (int c = 0; c < 6; c++) begin
      in_wr = {wr_pat[c], 1'b0};
      in_din = {words[widx], 64'h0};
      ddr_wait_req = wait_pat[c];
      @(negedge clk_sys);
      if (ddr_wr && !ddr_wait_req) begin
        got.push_back(ddr_din);
        check("write mask", ddr_mask, 8'h5A);
      end
      if (in_wr[1] && !wait_req[1] && widx < 2) widx++;
      tick();
    end
    in_wr = '0; ddr_wait_req = 1'b0;
    @(negedge clk_sys);
    check("write done pulse", done, 2'b10);
    check("write idle ddr_wr", ddr_wr, 1'b0);
    tick();
    @(negedge clk_sys);
    check("write done single", done, 2'b00);
    tick();
    check("write word count", got.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("write word %0d", k), (k < got.size()) ? got[k] : 64'hX, words[k]);

    // Port 1 requests during port 0's READ_DATA.
    do_reset();
    in_burst_len = {8'd2, 8'd2};
    in_rd = 2'b01;
    tick();
    @(negedge clk_sys);
    check("mid cmd ddr_rd", ddr_rd, 1'b1);
    tick();
    in_rd = 2'b10; ddr_valid = 1'b1;
    @(negedge clk_sys);
    check("mid data1 wait1", wait_req[1], 1'b1);
    check("mid data1 valid", valid, 2'b01);
    check("mid data1 ddr_rd", ddr_rd, 1'b0);
    tick();
    ddr_valid = 1'b0;
    @(negedge clk_sys);
    check("mid gap wait1", wait_req[1], 1'b1);
    tick();
    ddr_valid = 1'b1;
    @(negedge clk_sys);
    check("mid data2 wait", wait_req, 2'b11);
    check("mid data2 valid", valid, 2'b01);
    tick();
    ddr_valid = 1'b0;
    @(negedge clk_sys);
    check("mid done0", done, 2'b01);
    check("mid idle wait", wait_req, 2'b11);
    check("mid idle ddr_rd", ddr_rd, 1'b0);
    tick();
    @(negedge clk_sys);
    check("mid port1 ddr_rd", ddr_rd, 1'b1);
    check("mid port1 wait", wait_req, 2'b01);
    check("mid port1 addr", ddr_addr, 32'h200);
    tick();

    // Reset asserted mid-burst, then port 0 must win first after release.
    do_reset();
    in_burst_len = {8'd4, 8'd4};
    in_rd = 2'b01;
    tick();
    tick();
    in_rd = 2'b11; ddr_valid = 1'b1;
    @(negedge clk_sys);
    check("rst pre valid", valid, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async valid", valid, 2'b00);
    check("rst async wait", wait_req, 2'b11);
    check("rst async ddr_rd", ddr_rd, 1'b0);
    check("rst async done", done, 2'b00);
    ddr_valid = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    tick();
    @(negedge clk_sys);
    check("rst first grant ddr_rd", ddr_rd, 1'b1);
    check("rst first grant wait", wait_req, 2'b10);
    check("rst first grant addr", ddr_addr, 32'h100);
    in_rd = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ddr_arbiter
